// File: rtl/bwt_codec.sv
// ---------------------------------------------------------------------------
// bwt_codec
// Handshaked Burrows-Wheeler engine. Each frame is either forward
// (string -> L column + primary index) or inverse (L column + primary
// index -> string), chosen by i_mode on the start pulse.
//
// Ports
//   i_clk, i_rst_n      rising-edge clock, asynchronous active-low reset
//   i_mode              0 = forward, 1 = inverse (latched on i_start)
//   i_start             one-cycle pulse in IDLE that opens a frame
//   i_primary_in        primary index for inverse frames (latched on i_start)
//   i_in_valid/o_in_ready/i_in_data/i_in_last    input symbol stream
//   o_out_valid/i_out_ready/o_out_data/o_out_last output symbol stream
//   o_primary_out       forward: row of the original string; inverse: 0
//   o_busy              high in every state except IDLE
//   o_err               one-cycle pulse when a frame is aborted
// ---------------------------------------------------------------------------
module bwt_codec #(
    parameter int SYM_W   = 8,
    parameter int MAX_LEN = 1024,
    parameter int ADDR_W  = 10
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_mode,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_primary_in,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [SYM_W-1:0]  i_in_data,
    input  logic              i_in_last,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [SYM_W-1:0]  o_out_data,
    output logic              o_out_last,
    output logic [ADDR_W-1:0] o_primary_out,
    output logic              o_busy,
    output logic              o_err
);

    localparam int NSYM = 2 ** SYM_W;
    // One counter width wide enough for frame lengths (up to MAX_LEN) and
    // for walking every symbol value in PREFIX.
    localparam int CW   = ((ADDR_W + 1) > (SYM_W + 1)) ? (ADDR_W + 1) : (SYM_W + 1);

    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] MAXL     = CW'(MAX_LEN);
    localparam logic [CW-1:0] LAST_SYM = CW'(NSYM - 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, SORT, COUNT, PREFIX, RANK, WALK, EMIT
    } state_t;

    state_t r_state;
    state_t w_next;

    logic              r_mode;
    logic [ADDR_W-1:0] r_primaryIn;
    logic [CW-1:0]     r_len;
    logic [ADDR_W-1:0] r_j;
    logic [CW-1:0]     r_k;
    logic              r_swapped;
    logic [ADDR_W-1:0] r_primary;
    logic [CW-1:0]     r_idx;
    logic [ADDR_W-1:0] r_p;
    logic [CW-1:0]     r_sum;

    logic [SYM_W-1:0]  r_s   [MAX_LEN];
    logic [ADDR_W-1:0] r_sa  [MAX_LEN];
    logic [ADDR_W-1:0] r_lf  [MAX_LEN];
    logic [SYM_W-1:0]  r_t   [MAX_LEN];
    logic [CW-1:0]     r_cnt [NSYM];
    logic [CW-1:0]     r_c   [NSYM];

    // Reduces x (< 2n) modulo the frame length n.
    function automatic logic [ADDR_W-1:0] wrapN(input logic [CW-1:0] x,
                                                input logic [CW-1:0] n);
        logic [CW-1:0] y;
        y = (x >= n) ? (x - n) : x;
        return y[ADDR_W-1:0];
    endfunction

    logic              w_inFire;
    logic              w_overflow;
    logic              w_loadEnd;
    logic              w_primaryBad;
    logic [CW-1:0]     w_nm1;
    logic [ADDR_W-1:0] w_j1;
    logic [ADDR_W-1:0] w_ia;
    logic [ADDR_W-1:0] w_ib;
    logic [SYM_W-1:0]  w_symA;
    logic [SYM_W-1:0]  w_symB;
    logic              w_gt;
    logic              w_lt;
    logic              w_pairDone;
    logic              w_lastPair;
    logic              w_sortDone;
    logic [SYM_W-1:0]  w_cntSym;
    logic              w_outFire;
    logic [CW-1:0]     w_emitIdx;
    logic [ADDR_W-1:0] w_fwdIdx;
    logic [SYM_W-1:0]  w_emitSym;
    logic              w_emitLoad;

    assign o_in_ready = (r_state == LOAD);
    assign o_busy     = (r_state != IDLE);

    // Input side: a handshake beyond MAX_LEN symbols aborts the frame even
    // if it carries in_last, since there is nowhere to store it.
    assign w_inFire     = o_in_ready && i_in_valid;
    assign w_overflow   = w_inFire && (r_len == MAXL);
    assign w_loadEnd    = w_inFire && i_in_last && !w_overflow;
    assign w_primaryBad = r_mode && ({{(CW-ADDR_W){1'b0}}, r_primaryIn} >= (r_len + ONE));

    // Sort: compare rotations starting at sa[j] and sa[j+1], one symbol
    // pair (offset k) per cycle.
    assign w_nm1      = r_len - ONE;
    assign w_j1       = r_j + 1'b1;
    assign w_ia       = wrapN({{(CW-ADDR_W){1'b0}}, r_sa[r_j]} + r_k, r_len);
    assign w_ib       = wrapN({{(CW-ADDR_W){1'b0}}, r_sa[w_j1]} + r_k, r_len);
    assign w_symA     = r_s[w_ia];
    assign w_symB     = r_s[w_ib];
    assign w_gt       = (w_symA > w_symB);
    assign w_lt       = (w_symA < w_symB);
    assign w_pairDone = w_gt || w_lt || (r_k == w_nm1);
    assign w_lastPair = (({{(CW-ADDR_W){1'b0}}, r_j} + ONE) == w_nm1);
    assign w_sortDone = (r_len == ONE) ||
                        (w_pairDone && w_lastPair && !r_swapped && !w_gt);

    assign w_cntSym  = r_s[r_idx[ADDR_W-1:0]];
    assign w_outFire = o_out_valid && i_out_ready;

    // Output symbol for the next EMIT index. On the final WALK step T[0]
    // is still being written, so the symbol is taken straight from L[p].
    assign w_emitIdx  = (r_state == EMIT) ? (r_idx + ONE) : '0;
    assign w_fwdIdx   = wrapN({{(CW-ADDR_W){1'b0}}, r_sa[w_emitIdx[ADDR_W-1:0]]} + w_nm1, r_len);
    assign w_emitSym  = r_mode ? ((r_state == WALK) ? r_s[r_p] : r_t[w_emitIdx[ADDR_W-1:0]])
                               : r_s[w_fwdIdx];
    assign w_emitLoad = ((r_state == SORT) && w_sortDone) ||
                        ((r_state == WALK) && (r_idx == '0)) ||
                        ((r_state == EMIT) && w_outFire && !o_out_last);

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:   if (i_start) w_next = LOAD;
            LOAD: begin
                if (w_overflow)                  w_next = IDLE;
                else if (w_loadEnd && w_primaryBad) w_next = IDLE;
                else if (w_loadEnd)              w_next = r_mode ? COUNT : SORT;
            end
            SORT:   if (w_sortDone)              w_next = EMIT;
            COUNT:  if (r_idx == w_nm1)          w_next = PREFIX;
            PREFIX: if (r_idx == LAST_SYM)       w_next = RANK;
            RANK:   if (r_idx == w_nm1)          w_next = WALK;
            WALK:   if (r_idx == '0)             w_next = EMIT;
            EMIT:   if (w_outFire && o_out_last) w_next = IDLE;
            default:                             w_next = IDLE;
        endcase
    end

    // Control registers and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mode        <= 1'b0;
            r_primaryIn   <= '0;
            r_len         <= '0;
            r_j           <= '0;
            r_k           <= '0;
            r_swapped     <= 1'b0;
            r_primary     <= '0;
            r_idx         <= '0;
            r_p           <= '0;
            r_sum         <= '0;
            o_out_valid   <= 1'b0;
            o_out_data    <= '0;
            o_out_last    <= 1'b0;
            o_primary_out <= '0;
            o_err         <= 1'b0;
        end else begin
            o_err <= w_overflow || (w_loadEnd && w_primaryBad);
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_mode      <= i_mode;
                        r_primaryIn <= i_primary_in;
                        r_len       <= '0;
                    end
                end
                LOAD: begin
                    if (w_inFire && !w_overflow) r_len <= r_len + ONE;
                    if (w_loadEnd) begin
                        r_j       <= '0;
                        r_k       <= '0;
                        r_swapped <= 1'b0;
                        r_primary <= '0;
                        r_idx     <= '0;
                    end
                end
                SORT: begin
                    if (r_len != ONE) begin
                        // Track where rotation 0 ends up as it moves.
                        if (w_gt) begin
                            r_swapped <= 1'b1;
                            if (r_sa[r_j] == '0)       r_primary <= w_j1;
                            else if (r_sa[w_j1] == '0) r_primary <= r_j;
                        end
                        if (w_pairDone) begin
                            r_k <= '0;
                            if (w_lastPair) begin
                                r_j       <= '0;
                                r_swapped <= 1'b0;
                            end else begin
                                r_j <= w_j1;
                            end
                        end else begin
                            r_k <= r_k + ONE;
                        end
                    end
                end
                COUNT: begin
                    r_idx <= r_idx + ONE;
                    if (r_idx == w_nm1) begin
                        r_idx <= '0;
                        r_sum <= '0;
                    end
                end
                PREFIX: begin
                    r_sum <= r_sum + r_cnt[r_idx[SYM_W-1:0]];
                    r_idx <= r_idx + ONE;
                    if (r_idx == LAST_SYM) r_idx <= '0;
                end
                RANK: begin
                    r_idx <= r_idx + ONE;
                    if (r_idx == w_nm1) begin
                        r_idx <= w_nm1;
                        r_p   <= r_primaryIn;
                    end
                end
                WALK: begin
                    r_p   <= r_lf[r_p];
                    r_idx <= r_idx - ONE;
                end
                default: ;
            endcase

            if (w_emitLoad) begin
                o_out_valid   <= 1'b1;
                o_out_data    <= w_emitSym;
                o_out_last    <= (w_emitIdx == w_nm1);
                o_primary_out <= r_mode ? '0 : r_primary;
                r_idx         <= w_emitIdx;
            end else if ((r_state == EMIT) && w_outFire && o_out_last) begin
                o_out_valid <= 1'b0;
                o_out_last  <= 1'b0;
            end
        end
    end

    // Frame memories; contents are don't-care after reset.
    always_ff @(posedge i_clk) begin
        if (w_inFire && !w_overflow) begin
            r_s[r_len[ADDR_W-1:0]]  <= i_in_data;
            r_sa[r_len[ADDR_W-1:0]] <= r_len[ADDR_W-1:0];
        end
        if (w_loadEnd && r_mode) begin
            for (int c = 0; c < NSYM; c++) r_cnt[c] <= '0;
        end
        case (r_state)
            SORT: begin
                if ((r_len != ONE) && w_gt) begin
                    r_sa[r_j]  <= r_sa[w_j1];
                    r_sa[w_j1] <= r_sa[r_j];
                end
            end
            COUNT: r_cnt[w_cntSym] <= r_cnt[w_cntSym] + ONE;
            PREFIX: begin
                r_c[r_idx[SYM_W-1:0]] <= r_sum;
                // Counters are reused as the occurrence counts for RANK.
                if (r_idx == LAST_SYM) begin
                    for (int c = 0; c < NSYM; c++) r_cnt[c] <= '0;
                end
            end
            RANK: begin
                r_lf[r_idx[ADDR_W-1:0]] <= ADDR_W'(r_c[w_cntSym] + r_cnt[w_cntSym]);
                r_cnt[w_cntSym]         <= r_cnt[w_cntSym] + ONE;
            end
            WALK: r_t[r_idx[ADDR_W-1:0]] <= r_s[r_p];
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bwt_codec.sv
// ---------------------------------------------------------------------------
// tb_bwt_codec
// Self-checking bench for bwt_codec. Expected output symbols are pushed to a
// scoreboard queue as each frame is driven and popped as the DUT emits them.
// ---------------------------------------------------------------------------
module tb_bwt_codec;

    localparam int SYM_W   = 8;
    localparam int MAX_LEN = 1024;
    localparam int ADDR_W  = 10;

    logic              clk;
    logic              rstN;
    logic              mode;
    logic              start;
    logic [ADDR_W-1:0] primaryIn;
    logic              inValid;
    logic              inReady;
    logic [SYM_W-1:0]  inData;
    logic              inLast;
    logic              outValid;
    logic              outReady;
    logic [SYM_W-1:0]  outData;
    logic              outLast;
    logic [ADDR_W-1:0] primaryOut;
    logic              busy;
    logic              err;

    typedef struct {
        logic [SYM_W-1:0]  data;
        logic              last;
        logic [ADDR_W-1:0] prim;
    } exp_t;

    exp_t expQ[$];

    int nAssert = 0;
    int nFail   = 0;
    int errCount   = 0;
    int validCount = 0;

    bwt_codec #(.SYM_W(SYM_W), .MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W)) dut (
        .i_clk         (clk),
        .i_rst_n       (rstN),
        .i_mode        (mode),
        .i_start       (start),
        .i_primary_in  (primaryIn),
        .i_in_valid    (inValid),
        .o_in_ready    (inReady),
        .i_in_data     (inData),
        .i_in_last     (inLast),
        .o_out_valid   (outValid),
        .i_out_ready   (outReady),
        .o_out_data    (outData),
        .o_out_last    (outLast),
        .o_primary_out (primaryOut),
        .o_busy        (busy),
        .o_err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event monitors sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (err)      errCount++;
        if (outValid) validCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nAssert++;
        assert (obs === expv)
        else begin
            nFail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic pushExpected(input string s, input int prim);
        exp_t e;
        for (int i = 0; i < s.len(); i++) begin
            e.data = s[i];
            e.last = (i == s.len() - 1);
            e.prim = ADDR_W'(prim);
            expQ.push_back(e);
        end
    endtask

    // Opens a frame and streams string s into the DUT.
    task automatic applyStimulus(input logic m, input int prim, input string s);
        int waited;
        @(negedge clk);
        mode      = m;
        primaryIn = ADDR_W'(prim);
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < s.len(); i++) begin
            inValid = 1'b1;
            inData  = s[i];
            inLast  = (i == s.len() - 1);
            waited  = 0;
            while (!inReady && waited < 50) begin
                @(negedge clk);
                waited++;
            end
            checkOutput("in_ready", inReady, 1);
            @(negedge clk);
        end
        inValid = 1'b0;
        inLast  = 1'b0;
    endtask

    // Drains the scoreboard; every cycle with out_valid is compared against
    // the queue head, so stalled cycles also prove the outputs hold.
    task automatic collectOutput(input bit randomReady);
        int   cycles;
        exp_t e;
        cycles = 0;
        while (expQ.size() > 0 && cycles < 20000) begin
            @(negedge clk);
            cycles++;
            outReady = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
            if (outValid) begin
                e = expQ[0];
                checkOutput("out_data", outData, e.data);
                checkOutput("out_last", outLast, e.last);
                checkOutput("primary_out", primaryOut, e.prim);
                if (outReady) void'(expQ.pop_front());
            end
        end
        checkOutput("emit_timeout", (expQ.size() == 0), 1);
        expQ.delete();
        @(negedge clk);
        checkOutput("out_valid_after", outValid, 0);
        checkOutput("busy_after", busy, 0);
        outReady = 1'b0;
    endtask

    initial begin
        int errBase;
        int validBase;

        rstN      = 1'b0;
        mode      = 1'b0;
        start     = 1'b0;
        primaryIn = '0;
        inValid   = 1'b0;
        inData    = '0;
        inLast    = 1'b0;
        outReady  = 1'b0;

        #12;
        checkOutput("rst_in_ready", inReady, 0);
        checkOutput("rst_out_valid", outValid, 0);
        checkOutput("rst_out_last", outLast, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_out_data", outData, 0);
        checkOutput("rst_primary_out", primaryOut, 0);
        @(negedge clk);
        rstN = 1'b1;

        // in_valid without a start is ignored
        inValid = 1'b1;
        inData  = 8'h41;
        repeat (2) @(negedge clk);
        checkOutput("idle_in_ready", inReady, 0);
        checkOutput("idle_busy", busy, 0);
        inValid = 1'b0;

        $display("[TB] forward banana");
        pushExpected("nnbaaa", 3);
        applyStimulus(1'b0, 0, "banana");
        collectOutput(1'b0);

        $display("[TB] inverse nnbaaa, primary 3");
        pushExpected("banana", 0);
        applyStimulus(1'b1, 3, "nnbaaa");
        collectOutput(1'b0);

        $display("[TB] forward abc");
        pushExpected("cab", 0);
        applyStimulus(1'b0, 0, "abc");
        collectOutput(1'b0);

        $display("[TB] forward aaaa");
        pushExpected("aaaa", 0);
        applyStimulus(1'b0, 0, "aaaa");
        collectOutput(1'b0);

        $display("[TB] forward single symbol");
        pushExpected("x", 0);
        applyStimulus(1'b0, 0, "x");
        collectOutput(1'b0);

        $display("[TB] forward banana with random backpressure");
        pushExpected("nnbaaa", 3);
        applyStimulus(1'b0, 0, "banana");
        collectOutput(1'b1);

        $display("[TB] overflow without in_last");
        errBase   = errCount;
        validBase = validCount;
        @(negedge clk);
        mode  = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        inValid = 1'b1;
        inLast  = 1'b0;
        inData  = 8'h5a;
        repeat (MAX_LEN + 1) @(negedge clk);
        inValid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("ovf_err_pulses", errCount - errBase, 1);
        checkOutput("ovf_no_output", validCount - validBase, 0);
        checkOutput("ovf_busy", busy, 0);
        checkOutput("ovf_in_ready", inReady, 0);

        $display("[TB] inverse with primary out of range");
        errBase   = errCount;
        validBase = validCount;
        applyStimulus(1'b1, 6, "nnbaaa");
        repeat (3) @(negedge clk);
        checkOutput("prim_err_pulses", errCount - errBase, 1);
        checkOutput("prim_no_output", validCount - validBase, 0);
        checkOutput("prim_busy", busy, 0);

        $display("[TB] reset during sort");
        applyStimulus(1'b0, 0, "banana");
        repeat (5) @(negedge clk);
        checkOutput("sort_busy", busy, 1);
        #1 rstN = 1'b0;
        #1;
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_out_valid", outValid, 0);
        checkOutput("mid_rst_out_data", outData, 0);
        checkOutput("mid_rst_out_last", outLast, 0);
        checkOutput("mid_rst_primary", primaryOut, 0);
        checkOutput("mid_rst_in_ready", inReady, 0);
        checkOutput("mid_rst_err", err, 0);
        @(negedge clk);
        rstN = 1'b1;

        pushExpected("cab", 0);
        applyStimulus(1'b0, 0, "abc");
        collectOutput(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
